// File: rtl/pipe_dmem_arb_if.sv
// Bus bundle for pipe_dmem_arb: MEM-stage port, host (debug/loader) port,
// shared data-RAM port, pipeline stall and performance counters.
// The slave modport is the arbiter's view; master is the surrounding system.
interface pipe_dmem_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_stall;
  logic [15:0] host_grant_cnt;
  logic [15:0] stall_cycle_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_rdata, host_ack, host_rdata,
    output mem_we, mem_addr, mem_wdata,
    output cpu_stall, host_grant_cnt, stall_cycle_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_rdata, host_ack, host_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  cpu_stall, host_grant_cnt, stall_cycle_cnt
  );
endinterface

// File: rtl/pipe_dmem_arb.sv
// pipe_dmem_arb: shares the single data-RAM port between the pipeline MEM
// stage (priority owner) and a host debug/loader port. The host only gets the
// port in cycles where the CPU does not use it; if it is starved for more than
// STARVE_LIMIT contended cycles the pipeline is asked to stall.
// Optional feature macro: DMEM_ARB_PERF_EN enables the saturating
// performance counters; when undefined both counter outputs are tied to 0.
module pipe_dmem_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            resetn,
  pipe_dmem_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_nxt_s;
  logic        access_s;
  logic        host_own_s;
  logic        host_ack_r;
  logic        cpu_stall_r;
  logic [31:0] host_rdata_r;

  // The host owns the port only in a cycle the CPU leaves free; never during ACK.
  assign access_s   = (state_r != ACK) && bus.host_req && !bus.cpu_req;
  // While reset is held the CPU always owns the port.
  assign host_own_s = access_s && resetn;

  // Shared RAM port mux: host when it owns the cycle, CPU otherwise.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (host_own_s) begin
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end else begin
      bus.mem_we    = bus.cpu_req && bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.host_ack   = host_ack_r;
  assign bus.cpu_stall  = cpu_stall_r;
  assign bus.host_rdata = host_rdata_r;

  // Next-state and wait-counter logic for the host arbitration FSM.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          state_nxt_s    = ACK;
          wait_cnt_nxt_s = 8'd0;
        end else if (bus.host_req && bus.cpu_req) begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 8'd0;
        end
      end
      WAIT: begin
        if (access_s) begin
          state_nxt_s    = ACK;
          wait_cnt_nxt_s = 8'd0;
        end else if (!bus.host_req) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else if ((wait_cnt_r == LIMIT_C) && bus.cpu_req) begin
          state_nxt_s    = STALL;
          wait_cnt_nxt_s = wait_cnt_r;
        end else begin
          state_nxt_s    = WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      STALL: begin
        if (access_s) begin
          state_nxt_s    = ACK;
          wait_cnt_nxt_s = 8'd0;
        end else if (!bus.host_req) begin
          state_nxt_s    = IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = STALL;
          wait_cnt_nxt_s = wait_cnt_r;
        end
      end
      ACK: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
      default: begin
        state_nxt_s    = IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State and wait-counter registers; reset drops any pending host request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Moore outputs registered from the next state so they track state exactly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      host_ack_r  <= 1'b0;
      cpu_stall_r <= 1'b0;
    end else begin
      host_ack_r  <= (state_nxt_s == ACK);
      cpu_stall_r <= (state_nxt_s == STALL);
    end
  end

  // Capture RAM read data at the edge ending a host access; hold otherwise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      host_rdata_r <= 32'd0;
    end else if (access_s) begin
      host_rdata_r <= bus.mem_rdata;
    end else begin
      host_rdata_r <= host_rdata_r;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] grant_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating counters: host grants (ACK entries) and stalled cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant_cnt_r <= 16'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      if (access_s && (grant_cnt_r != 16'hFFFF)) begin
        grant_cnt_r <= grant_cnt_r + 16'd1;
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
      if (cpu_stall_r && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.host_grant_cnt  = grant_cnt_r;
  assign bus.stall_cycle_cnt = stall_cnt_r;
`else
  assign bus.host_grant_cnt  = 16'd0;
  assign bus.stall_cycle_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_dmem_arb.sv
// Self-checking bench for pipe_dmem_arb: directed scenarios followed by
// randomized CPU/host traffic, checked against a cycle-level reference model
// that tracks host ownership, consecutive blocked cycles and a shadow memory.
module tb_pipe_dmem_arb;
  localparam int LIMIT = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [31:0] host_addr = 32'd0, host_wdata = 32'd0;

  logic [31:0] ram    [256];
  logic [31:0] shadow [256];

  // reference model state
  logic        m_ack;
  int          m_blocked;
  logic [31:0] m_rdata;
  logic [15:0] m_grant, m_stalls;

  int n_checks = 0;
  int n_errors = 0;

  pipe_dmem_arb_if bus();

  assign bus.cpu_req    = cpu_req;
  assign bus.cpu_we     = cpu_we;
  assign bus.cpu_addr   = cpu_addr;
  assign bus.cpu_wdata  = cpu_wdata;
  assign bus.host_req   = host_req;
  assign bus.host_we    = host_we;
  assign bus.host_addr  = host_addr;
  assign bus.host_wdata = host_wdata;
  assign bus.mem_rdata  = ram[bus.mem_addr[9:2]];

  pipe_dmem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  task automatic check_regs();
    logic [15:0] eg, es;
`ifdef DMEM_ARB_PERF_EN
    eg = m_grant;
    es = m_stalls;
`else
    eg = 16'd0;
    es = 16'd0;
`endif
    check_eq("host_ack", {31'd0, bus.host_ack}, {31'd0, m_ack});
    check_eq("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, (m_blocked > LIMIT)});
    check_eq("host_rdata", bus.host_rdata, m_rdata);
    check_eq("host_grant_cnt", {16'd0, bus.host_grant_cnt}, {16'd0, eg});
    check_eq("stall_cycle_cnt", {16'd0, bus.stall_cycle_cnt}, {16'd0, es});
  endtask

  // One clock cycle: check the port mux, advance the model, check registered outputs.
  task automatic step();
    logic        acc, ewe, we_q;
    logic [31:0] ea, ew, a_q, d_q;
    #1;
    acc = !m_ack && host_req && !cpu_req;
    if (acc) begin
      ewe = host_we;  ea = host_addr; ew = host_wdata;
    end else begin
      ewe = cpu_req && cpu_we; ea = cpu_addr; ew = cpu_wdata;
    end
    check_eq("mem_we", {31'd0, bus.mem_we}, {31'd0, ewe});
    check_eq("mem_addr", bus.mem_addr, ea);
    check_eq("mem_wdata", bus.mem_wdata, ew);
    check_eq("cpu_rdata", bus.cpu_rdata, shadow[ea[9:2]]);
    if (acc) m_rdata = shadow[ea[9:2]];
    if (ewe) shadow[ea[9:2]] = ew;
    if ((m_blocked > LIMIT) && (m_stalls != 16'hFFFF)) m_stalls++;
    if (acc && (m_grant != 16'hFFFF)) m_grant++;
    if (m_ack || acc || !host_req) m_blocked = 0;
    else if (m_blocked <= LIMIT) m_blocked++;
    m_ack = acc;
    we_q = bus.mem_we; a_q = bus.mem_addr; d_q = bus.mem_wdata;
    @(posedge clock);
    #1;
    if (we_q) ram[a_q[9:2]] = d_q;
    check_regs();
  endtask

  // Hold reset across one rising edge; the CPU idles so the RAM is untouched.
  task automatic do_reset();
    cpu_req = 1'b0;
    resetn  = 1'b0;
    #1;
    m_ack = 1'b0; m_blocked = 0; m_rdata = 32'd0; m_grant = 16'd0; m_stalls = 16'd0;
    check_regs();
    check_eq("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clock);
    #1;
    check_regs();
    check_eq("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int bias;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    ram[16]    = 32'h1234_5678;
    shadow[16] = 32'h1234_5678;

    do_reset();

    // uncontended read of 0x40
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
    step();
    check_eq("unc_ack", {31'd0, bus.host_ack}, 32'd1);
    check_eq("unc_rdata", bus.host_rdata, 32'h1234_5678);
    host_req = 1'b0;
    step();

    // contended write: CPU busy 3 cycles, host write lands on the 4th
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h44; host_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) step();
    cpu_req = 1'b0;
    step();
    check_eq("cw_ack", {31'd0, bus.host_ack}, 32'd1);
    host_we = 1'b0;
    step();
    step();
    check_eq("cw_readback", bus.host_rdata, 32'hCAFE_F00D);
    host_req = 1'b0;
    step();

    // starvation: CPU holds the port until the stall is forced
    cpu_req = 1'b1; host_req = 1'b1; host_addr = 32'h40;
    for (int i = 0; i < LIMIT + 2; i++) step();
    check_eq("starve_stall", {31'd0, bus.cpu_stall}, 32'd1);
    cpu_req = 1'b0;
    step();
    check_eq("starve_ack", {31'd0, bus.host_ack}, 32'd1);
    check_eq("starve_ack_nostall", {31'd0, bus.cpu_stall}, 32'd0);
    host_req = 1'b0;
    step();

    // withdrawal while stalled
    cpu_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < LIMIT + 2; i++) step();
    host_req = 1'b0;
    step();
    check_eq("wd_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check_eq("wd_ack", {31'd0, bus.host_ack}, 32'd0);
    cpu_req = 1'b0;
    step();

    // reset while waiting, then reissue
    cpu_req = 1'b1; host_req = 1'b1; host_addr = 32'h40;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    step();
    check_eq("rst_reissue_ack", {31'd0, bus.host_ack}, 32'd1);
    check_eq("rst_reissue_data", bus.host_rdata, 32'h1234_5678);
    host_req = 1'b0;
    step();

    // randomized traffic
    bias = 50;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 300) == 0) bias = ($urandom_range(0, 2) == 0) ? 30 : (($urandom_range(0, 1) == 0) ? 70 : 95);
      if (bus.cpu_stall) cpu_req = 1'b0;
      else cpu_req = ($urandom_range(0, 99) < bias);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rand_addr();
      cpu_wdata = $urandom;
      if (bus.host_ack || !host_req) begin
        if (bus.host_ack || ($urandom_range(0, 2) == 0)) begin
          host_req   = 1'($urandom_range(0, 1));
          host_we    = 1'($urandom_range(0, 1));
          host_addr  = rand_addr();
          host_wdata = $urandom;
        end
      end else if ($urandom_range(0, 31) == 0) begin
        host_req = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
